pill_feeder: RTL and testbench

Pill-source model for the bottling line: the transmitting end of the pill-pulse interface that the bottling counter consumes as its QD count input. It holds a hopper level and emits one-cycle pill pulses at a fixed rate while the controller is running. It pauses for conveyor indexing after each finished bottle and honours the hopper-stop, conveyor-stop, manual-add and emergency-stop inputs. It runs on the 1 kHz system clock, alongside the counter/display controller.

---
 rtl/pill_line_pkg.sv | 30 +++
 rtl/rise_pulse.sv | 30 +++
 rtl/pill_feeder.sv | 166 ++++++++++++++++
 tb/tb_pill_feeder.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pill_line_pkg.sv
// pill_line_pkg: definitions shared by the pill feeder and the bottling controller.
//   - feeder state encoding (localparams plus a typed enum built from them)
//   - hopper_level width, which the controller also uses
//   - default values for the feeder parameters
package pill_line_pkg;

    localparam int unsigned HOPPER_W = 10;

    localparam logic [2:0] FS_IDLE  = 3'd0;
    localparam logic [2:0] FS_FEED  = 3'd1;
    localparam logic [2:0] FS_INDEX = 3'd2;
    localparam logic [2:0] FS_HOLD  = 3'd3;
    localparam logic [2:0] FS_ESTOP = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = FS_IDLE,
        StFeed  = FS_FEED,
        StIndex = FS_INDEX,
        StHold  = FS_HOLD,
        StEstop = FS_ESTOP
    } feeder_state_e;

    localparam int unsigned PILL_PERIOD_DEF   = 250;
    localparam int unsigned INDEX_CYCLES_DEF  = 1000;
    localparam int unsigned HOPPER_MAX_DEF    = 999;
    localparam int unsigned HOPPER_INIT_DEF   = 200;
    localparam int unsigned REFILL_AMOUNT_DEF = 100;
    localparam int unsigned LOW_THRESH_DEF    = 20;

endpackage

// File: rtl/rise_pulse.sv
// rise_pulse: one-flop rising-edge detector.
//   clk_1khz   in  system clock
//   switch_clr in  asynchronous active-low reset (clears the history flop)
//   sig_i      in  level input
//   rise_o     out high for the cycle in which sig_i is high and was low last cycle
module rise_pulse (
    input  logic clk_1khz,
    input  logic switch_clr,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig_i;
    end

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/pill_feeder.sv
// pill_feeder: pill-source model driving the bottling counter's pill-pulse input.
// Emits one-cycle pills every PILL_PERIOD cycles while feeding, pauses INDEX_CYCLES
// after each bottle, holds on hopper/conveyor stop or empty hopper, latches e-stop.
//   clk_1khz           in   1 kHz system clock
//   switch_clr         in   asynchronous active-low reset
//   run_en             in   controller is RUNNING
//   bottle_done        in   one-cycle bottle-complete pulse
//   emergncy_stop      in   emergency stop (latched into ESTOP)
//   simu_hopper_stop   in   hopper gate closed
//   simu_hopper_add    in   raw manual-add button (edge adds REFILL_AMOUNT)
//   simu_conveyor_stop in   conveyor halted
//   pill_pulse         out  one-cycle pill pulse
//   hopper_level       out  pills in the hopper
//   feeder_state       out  state encoding (IDLE/FEED/INDEX/HOLD/ESTOP = 0..4)
//   hopper_empty       out  hopper_level == 0 (combinational)
//   fault              out  high in ESTOP
//   hopper_low         out  hopper_level < LOW_THRESH, only with HOPPER_LOW_WARN_EN
module pill_feeder
    import pill_line_pkg::*;
#(
    parameter int unsigned PILL_PERIOD   = PILL_PERIOD_DEF,
    parameter int unsigned INDEX_CYCLES  = INDEX_CYCLES_DEF,
    parameter int unsigned HOPPER_MAX    = HOPPER_MAX_DEF,
    parameter int unsigned HOPPER_INIT   = HOPPER_INIT_DEF,
    parameter int unsigned REFILL_AMOUNT = REFILL_AMOUNT_DEF
`ifdef HOPPER_LOW_WARN_EN
    ,
    parameter int unsigned LOW_THRESH    = LOW_THRESH_DEF
`endif
) (
    input  logic                clk_1khz,
    input  logic                switch_clr,
    input  logic                run_en,
    input  logic                bottle_done,
    input  logic                emergncy_stop,
    input  logic                simu_hopper_stop,
    input  logic                simu_hopper_add,
    input  logic                simu_conveyor_stop,
    output logic                pill_pulse,
    output logic [HOPPER_W-1:0] hopper_level,
    output logic [2:0]          feeder_state,
    output logic                hopper_empty,
    output logic                fault
`ifdef HOPPER_LOW_WARN_EN
    ,
    output logic                hopper_low
`endif
);

    localparam int unsigned PCNT_W = (PILL_PERIOD > 1) ? $clog2(PILL_PERIOD) : 1;
    localparam int unsigned ICNT_W = (INDEX_CYCLES > 1) ? $clog2(INDEX_CYCLES) : 1;

    feeder_state_e       state_q, state_d;
    logic [PCNT_W-1:0]   pill_cnt_q, pill_cnt_d;
    logic [ICNT_W-1:0]   idx_cnt_q, idx_cnt_d;
    logic [HOPPER_W-1:0] level_q, level_d;
    logic                pulse_q, pulse_d;
    logic                fault_q, fault_d;

    logic        add_rise;
    logic        hold_cause;
    logic        stay_feed;
    logic        pill_at_end;
    logic        fire;
    logic [31:0] level_sum;

    rise_pulse u_add_rise (
        .clk_1khz   (clk_1khz),
        .switch_clr (switch_clr),
        .sig_i      (simu_hopper_add),
        .rise_o     (add_rise)
    );

    assign hopper_empty = (level_q == '0);
    assign hold_cause   = simu_hopper_stop | simu_conveyor_stop | hopper_empty;

    // State register
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            state_q    <= StIdle;
            pill_cnt_q <= '0;
            idx_cnt_q  <= '0;
            level_q    <= HOPPER_W'(HOPPER_INIT);
            pulse_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pill_cnt_q <= pill_cnt_d;
            idx_cnt_q  <= idx_cnt_d;
            level_q    <= level_d;
            pulse_q    <= pulse_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state logic; e-stop and run_en override every per-state rule
    always_comb begin
        state_d = state_q;
        if (emergncy_stop || state_q == StEstop) begin
            state_d = StEstop;
        end else if (!run_en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  state_d = StFeed;
                StFeed: begin
                    if (hold_cause) begin
                        state_d = StHold;
                    end else if (bottle_done) begin
                        state_d = StIndex;
                    end
                end
                StHold: begin
                    if (!hold_cause) begin
                        state_d = StFeed;
                    end
                end
                StIndex: begin
                    // Hopper stop is deliberately not a cause here; conveyor stop only freezes
                    if (!simu_conveyor_stop && idx_cnt_q == ICNT_W'(INDEX_CYCLES - 1)) begin
                        state_d = StFeed;
                    end
                end
                default: state_d = StEstop;
            endcase
        end
    end

    // Counters, hopper arithmetic and registered outputs
    always_comb begin
        // A pill is only issued when FEED continues; leaving FEED drops the pending pill
        stay_feed   = (state_q == StFeed) && (state_d == StFeed);
        pill_at_end = (pill_cnt_q == PCNT_W'(PILL_PERIOD - 1));
        fire        = stay_feed && pill_at_end && !hopper_empty;

        pill_cnt_d = '0;
        if (stay_feed && !pill_at_end) begin
            pill_cnt_d = pill_cnt_q + 1'b1;
        end

        idx_cnt_d = '0;
        if (state_q == StIndex && state_d == StIndex) begin
            idx_cnt_d = simu_conveyor_stop ? idx_cnt_q : idx_cnt_q + 1'b1;
        end

        level_sum = 32'(level_q) + (add_rise ? 32'(REFILL_AMOUNT) : 32'd0) - 32'(fire);
        if (level_sum > 32'(HOPPER_MAX)) begin
            level_d = HOPPER_W'(HOPPER_MAX);
        end else begin
            level_d = level_sum[HOPPER_W-1:0];
        end

        pulse_d = fire;
        fault_d = (state_d == StEstop);
    end

    assign pill_pulse   = pulse_q;
    assign fault        = fault_q;
    assign feeder_state = state_q;
    assign hopper_level = level_q;

`ifdef HOPPER_LOW_WARN_EN
    assign hopper_low = (level_q < HOPPER_W'(LOW_THRESH));
`endif

endmodule

// File: tb/tb_pill_feeder.sv
module tb_pill_feeder;

    localparam int PP     = 4;
    localparam int IC     = 1000;
    localparam int MAXL   = 999;
    localparam int INIT   = 200;
    localparam int REFILL = 100;

    logic       clk_1khz;
    logic       switch_clr;
    logic       run_en;
    logic       bottle_done;
    logic       emergncy_stop;
    logic       simu_hopper_stop;
    logic       simu_hopper_add;
    logic       simu_conveyor_stop;
    logic       pill_pulse;
    logic [9:0] hopper_level;
    logic [2:0] feeder_state;
    logic       hopper_empty;
    logic       fault;
`ifdef HOPPER_LOW_WARN_EN
    logic       hopper_low;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: state by name-number, age since FEED entry, INDEX cycles remaining
    int m_state;
    int m_age;
    int m_idx_left;
    int m_level;
    bit m_pulse;
    bit m_prev_add;

    pill_feeder #(
        .PILL_PERIOD   (PP),
        .INDEX_CYCLES  (IC),
        .HOPPER_MAX    (MAXL),
        .HOPPER_INIT   (INIT),
        .REFILL_AMOUNT (REFILL)
    ) dut (
        .clk_1khz           (clk_1khz),
        .switch_clr         (switch_clr),
        .run_en             (run_en),
        .bottle_done        (bottle_done),
        .emergncy_stop      (emergncy_stop),
        .simu_hopper_stop   (simu_hopper_stop),
        .simu_hopper_add    (simu_hopper_add),
        .simu_conveyor_stop (simu_conveyor_stop),
        .pill_pulse         (pill_pulse),
        .hopper_level       (hopper_level),
        .feeder_state       (feeder_state),
        .hopper_empty       (hopper_empty),
        .fault              (fault)
`ifdef HOPPER_LOW_WARN_EN
        ,
        .hopper_low         (hopper_low)
`endif
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    task automatic model_reset();
        m_state    = 0;
        m_age      = 0;
        m_idx_left = 0;
        m_level    = INIT;
        m_pulse    = 0;
        m_prev_add = 0;
    endtask

    task automatic model_step();
        int ns;
        bit rise;
        bit causes;
        bit fire;
        rise   = simu_hopper_add && !m_prev_add;
        causes = simu_hopper_stop || simu_conveyor_stop || (m_level == 0);
        if (emergncy_stop || m_state == 4) ns = 4;
        else if (!run_en) ns = 0;
        else begin
            case (m_state)
                0: ns = 1;
                1: ns = causes ? 3 : (bottle_done ? 2 : 1);
                3: ns = causes ? 3 : 1;
                2: ns = (!simu_conveyor_stop && m_idx_left == 1) ? 1 : 2;
                default: ns = 4;
            endcase
        end
        fire = (m_state == 1) && (ns == 1) && ((m_age % PP) == PP - 1) && (m_level > 0);
        if (m_state == 1 && ns == 1) m_age++;
        else m_age = 0;
        if (ns == 2 && m_state != 2) m_idx_left = IC;
        else if (m_state == 2 && ns == 2 && !simu_conveyor_stop) m_idx_left--;
        m_level = m_level - int'(fire) + (rise ? REFILL : 0);
        if (m_level > MAXL) m_level = MAXL;
        m_pulse    = fire;
        m_prev_add = simu_hopper_add;
        m_state    = ns;
    endtask

    task automatic tick();
        @(posedge clk_1khz);
        if (switch_clr) model_step();
        else model_reset();
        #1;
    endtask

    task automatic do_reset();
        run_en             = 0;
        bottle_done        = 0;
        emergncy_stop      = 0;
        simu_hopper_stop   = 0;
        simu_hopper_add    = 0;
        simu_conveyor_stop = 0;
        switch_clr         = 0;
        tick();
        tick();
        switch_clr = 1;
    endtask

    task automatic press_add();
        simu_hopper_add = 1;
        tick();
        simu_hopper_add = 0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (feeder_state !== 3'd0) begin tests_failed++;
            $display("FAIL reset_state: got %0d expected 0", feeder_state); end
        tests_run++; if (pill_pulse !== 1'b0) begin tests_failed++;
            $display("FAIL reset_pulse: got %0b expected 0", pill_pulse); end
        tests_run++; if (hopper_level !== 10'(INIT)) begin tests_failed++;
            $display("FAIL reset_level: got %0d expected %0d", hopper_level, INIT); end
        tests_run++; if (hopper_empty !== 1'b0) begin tests_failed++;
            $display("FAIL reset_empty: got %0b expected 0", hopper_empty); end
        tests_run++; if (fault !== 1'b0) begin tests_failed++;
            $display("FAIL reset_fault: got %0b expected 0", fault); end
    endtask

    task automatic test_basic_feed();
        do_reset();
        run_en = 1;
        tick();
        tests_run++; if (feeder_state !== 3'd1) begin tests_failed++;
            $display("FAIL feed_entry: got %0d expected 1", feeder_state); end
        for (int i = 1; i <= 12; i++) begin
            tick();
            tests_run++; if (pill_pulse !== ((i % PP) == 0)) begin tests_failed++;
                $display("FAIL feed_pulse c%0d: got %0b expected %0b", i, pill_pulse,
                         (i % PP) == 0); end
            tests_run++; if (hopper_level !== 10'(INIT - i / PP)) begin tests_failed++;
                $display("FAIL feed_level c%0d: got %0d expected %0d", i, hopper_level,
                         INIT - i / PP); end
        end
    endtask

    task automatic test_index_pause();
        int n;
        int pulses;
        for (int pass = 0; pass < 2; pass++) begin
            bottle_done = 1;
            tick();
            bottle_done = 0;
            tests_run++; if (feeder_state !== 3'd2) begin tests_failed++;
                $display("FAIL index_entry p%0d: got %0d expected 2", pass, feeder_state); end
            n = 0;
            pulses = 0;
            while (feeder_state == 3'd2 && n < 3000) begin
                tick();
                n++;
                if (pill_pulse) pulses++;
                if (pass == 1 && n == 100) simu_conveyor_stop = 1;
                if (pass == 1 && n == 150) simu_conveyor_stop = 0;
            end
            tests_run++; if (n != (pass == 1 ? IC + 50 : IC)) begin tests_failed++;
                $display("FAIL index_len p%0d: got %0d expected %0d", pass, n,
                         pass == 1 ? IC + 50 : IC); end
            tests_run++; if (pulses != 0) begin tests_failed++;
                $display("FAIL index_pulses p%0d: got %0d expected 0", pass, pulses); end
        end
    endtask

    task automatic test_empty_refill();
        int n;
        int pulses;
        n = 0;
        while (hopper_level != 10'd2 && n < 5000) begin tick(); n++; end
        tests_run++; if (hopper_level !== 10'd2) begin tests_failed++;
            $display("FAIL drain_to_2: got %0d expected 2", hopper_level); end
        n = 0;
        pulses = 0;
        while (feeder_state != 3'd3 && n < 100) begin
            tick();
            n++;
            if (pill_pulse) pulses++;
        end
        tests_run++; if (pulses != 2) begin tests_failed++;
            $display("FAIL empty_pulses: got %0d expected 2", pulses); end
        tests_run++; if (feeder_state !== 3'd3) begin tests_failed++;
            $display("FAIL empty_hold: got %0d expected 3", feeder_state); end
        tests_run++; if (hopper_empty !== 1'b1) begin tests_failed++;
            $display("FAIL empty_flag: got %0b expected 1", hopper_empty); end
        simu_hopper_add = 1;
        tick();
        simu_hopper_add = 0;
        tests_run++; if (hopper_level !== 10'(REFILL)) begin tests_failed++;
            $display("FAIL refill_level: got %0d expected %0d", hopper_level, REFILL); end
        tick();
        tests_run++; if (feeder_state !== 3'd1) begin tests_failed++;
            $display("FAIL refill_resume: got %0d expected 1", feeder_state); end
        n = 0;
        while (!pill_pulse && n < 50) begin tick(); n++; end
        tests_run++; if (n != PP) begin tests_failed++;
            $display("FAIL refill_first_pill: got %0d cycles expected %0d", n, PP); end
    endtask

    task automatic test_saturation();
        int n;
        do_reset();
        run_en = 1;
        n = 0;
        while (hopper_level != 10'd150 && n < 2000) begin tick(); n++; end
        run_en = 0;
        tick();
        tests_run++; if (hopper_level !== 10'd150) begin tests_failed++;
            $display("FAIL sat_start: got %0d expected 150", hopper_level); end
        for (int k = 0; k < 8; k++) press_add();
        tests_run++; if (hopper_level !== 10'd950) begin tests_failed++;
            $display("FAIL sat_950: got %0d expected 950", hopper_level); end
        press_add();
        tests_run++; if (hopper_level !== 10'(MAXL)) begin tests_failed++;
            $display("FAIL sat_999: got %0d expected %0d", hopper_level, MAXL); end
        run_en = 1;
        n = 0;
        while (hopper_level != 10'd50 && n < 5000) begin tick(); n++; end
        tick();
        tick();
        tick();
        simu_hopper_add = 1;
        tick();
        simu_hopper_add = 0;
        tests_run++; if (pill_pulse !== 1'b1) begin tests_failed++;
            $display("FAIL simul_pulse: got %0b expected 1", pill_pulse); end
        tests_run++; if (hopper_level !== 10'd149) begin tests_failed++;
            $display("FAIL simul_level: got %0d expected 149", hopper_level); end
    endtask

    task automatic test_estop();
        int exp_level;
        emergncy_stop = 1;
        tick();
        emergncy_stop = 0;
        tests_run++; if (feeder_state !== 3'd4) begin tests_failed++;
            $display("FAIL estop_state: got %0d expected 4", feeder_state); end
        tests_run++; if (fault !== 1'b1) begin tests_failed++;
            $display("FAIL estop_fault: got %0b expected 1", fault); end
        for (int i = 0; i < 5; i++) tick();
        run_en = 0;
        tick();
        tick();
        run_en = 1;
        tick();
        tick();
        tests_run++; if (feeder_state !== 3'd4 || fault !== 1'b1) begin tests_failed++;
            $display("FAIL estop_latch: got state %0d fault %0b expected 4/1", feeder_state,
                     fault); end
        exp_level = (m_level + REFILL > MAXL) ? MAXL : m_level + REFILL;
        simu_hopper_add = 1;
        tick();
        simu_hopper_add = 0;
        tests_run++; if (hopper_level !== 10'(exp_level)) begin tests_failed++;
            $display("FAIL estop_refill: got %0d expected %0d", hopper_level, exp_level); end
        switch_clr = 0;
        #1;
        tests_run++; if (feeder_state !== 3'd0 || fault !== 1'b0) begin tests_failed++;
            $display("FAIL estop_clear: got state %0d fault %0b expected 0/0", feeder_state,
                     fault); end
        tick();
        switch_clr = 1;
    endtask

    task automatic test_priority();
        do_reset();
        run_en = 1;
        tick();
        tick();
        tick();
        tick();
        run_en      = 0;
        bottle_done = 1;
        tick();
        bottle_done = 0;
        tests_run++; if (feeder_state !== 3'd0) begin tests_failed++;
            $display("FAIL prio_state: got %0d expected 0", feeder_state); end
        tests_run++; if (pill_pulse !== 1'b0) begin tests_failed++;
            $display("FAIL prio_pulse: got %0b expected 0", pill_pulse); end
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        do_reset();
        run_en = 1;
        n = 0;
        while (!pill_pulse && n < 50) begin tick(); n++; end
        tests_run++; if (pill_pulse !== 1'b1) begin tests_failed++;
            $display("FAIL midrst_reach: got %0b expected 1", pill_pulse); end
        switch_clr = 0;
        #1;
        tests_run++; if (pill_pulse !== 1'b0) begin tests_failed++;
            $display("FAIL midrst_pulse: got %0b expected 0", pill_pulse); end
        tests_run++; if (hopper_level !== 10'(INIT)) begin tests_failed++;
            $display("FAIL midrst_level: got %0d expected %0d", hopper_level, INIT); end
        tick();
        switch_clr = 1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            run_en      = ($urandom_range(0, 99) < 95);
            bottle_done = ($urandom_range(0, 99) < 3);
            emergncy_stop = ($urandom_range(0, 999) < 2);
            if ($urandom_range(0, 99) < 3) simu_hopper_stop = ~simu_hopper_stop;
            if ($urandom_range(0, 99) < 3) simu_conveyor_stop = ~simu_conveyor_stop;
            if ($urandom_range(0, 99) < 8) simu_hopper_add = ~simu_hopper_add;
            switch_clr = !(m_state == 4 && $urandom_range(0, 99) < 5);
            tick();
            switch_clr = 1;
            tests_run++; if (pill_pulse !== m_pulse) begin tests_failed++;
                $display("FAIL rand_pulse c%0d: got %0b expected %0b", c, pill_pulse, m_pulse); end
            tests_run++; if (hopper_level !== 10'(m_level)) begin tests_failed++;
                $display("FAIL rand_level c%0d: got %0d expected %0d", c, hopper_level, m_level); end
            tests_run++; if (feeder_state !== 3'(m_state)) begin tests_failed++;
                $display("FAIL rand_state c%0d: got %0d expected %0d", c, feeder_state, m_state); end
            tests_run++; if (fault !== (m_state == 4)) begin tests_failed++;
                $display("FAIL rand_fault c%0d: got %0b expected %0b", c, fault, m_state == 4); end
            tests_run++; if (hopper_empty !== (m_level == 0)) begin tests_failed++;
                $display("FAIL rand_empty c%0d: got %0b expected %0b", c, hopper_empty,
                         m_level == 0); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_feed();
        test_index_pause();
        test_empty_refill();
        test_saturation();
        test_estop();
        test_priority();
        test_reset_mid_pulse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
